// File: rtl/audio_pkg.sv
// Shared audio-path definitions: PDM front-end defaults and the 8-bit PCM sample type
// used by the decimator, volume and PWM stages.
package audio_pkg;

  localparam int unsigned PDM_COUNT_PERIOD = 32;
  localparam int unsigned NUM_PDM_SAMPLES  = 256;
  localparam int unsigned OUT_WIDTH        = 8;

  typedef logic signed [7:0] pcm8_t;

  localparam pcm8_t PCM8_MAX = 8'sh7f;
  localparam pcm8_t PCM8_MIN = 8'sh80;

endpackage

// File: rtl/pdm_clk_gen.sv
// PDM microphone clock generator: registered 50% duty mic clock plus the sample strobe
// asserted in the last low cycle before each rising edge.
module pdm_clk_gen #(
  parameter int unsigned PDM_COUNT_PERIOD = audio_pkg::PDM_COUNT_PERIOD
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic en_in,
  output logic mic_clk_out,
  output logic strobe_c
);
  import audio_pkg::*;

  localparam int unsigned CNTW = $clog2(PDM_COUNT_PERIOD);
  localparam logic [CNTW-1:0] HALF_M1 = CNTW'(PDM_COUNT_PERIOD / 2 - 1);
  localparam logic [CNTW-1:0] LAST    = CNTW'(PDM_COUNT_PERIOD - 1);

  logic [CNTW-1:0] clk_cnt;

  // Disable parks the counter exactly like reset so re-enable restarts the phase.
  always_ff @(posedge clk_in) begin
    if (rst_in || !en_in) begin
      clk_cnt     <= '0;
      mic_clk_out <= 1'b0;
    end else begin
      clk_cnt <= (clk_cnt == LAST) ? '0 : clk_cnt + CNTW'(1);
      if (clk_cnt == HALF_M1) begin
        mic_clk_out <= 1'b1;
      end else if (clk_cnt == LAST) begin
        mic_clk_out <= 1'b0;
      end
    end
  end

  assign strobe_c = en_in && (clk_cnt == HALF_M1);

endmodule

// File: rtl/pdm_decimator.sv
// PDM-to-PCM box-car decimator: counts ones over each window and emits a saturated,
// signed, mid-scale-centred sample with a one-cycle valid strobe.
// Optional PDM_DC_REMOVE_EN adds a first-order DC tracker (one extra cycle of latency).
module pdm_decimator #(
  parameter int unsigned PDM_COUNT_PERIOD = audio_pkg::PDM_COUNT_PERIOD,
  parameter int unsigned NUM_PDM_SAMPLES  = audio_pkg::NUM_PDM_SAMPLES,
  parameter int unsigned OUT_WIDTH        = audio_pkg::OUT_WIDTH
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        en_in,
  input  logic                        mic_data_in,
  output logic                        mic_clk_out,
  output logic signed [OUT_WIDTH-1:0] audio_out,
  output logic                        audio_valid_out
);
  import audio_pkg::*;

  localparam int unsigned CW = $clog2(NUM_PDM_SAMPLES);
  localparam int unsigned TW = CW + 1;
  localparam int unsigned DW = OUT_WIDTH + 2;
  localparam logic signed [DW-1:0] OUT_MAX = DW'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [DW-1:0] OUT_MIN = DW'(-(1 << (OUT_WIDTH - 1)));

  logic                        strobe_c;
  logic                        close_c;
  logic [CW-1:0]               bit_cnt;
  logic [TW-1:0]               tally;
  logic [TW-1:0]               tally_final_c;
  logic signed [DW-1:0]        centred_c;
  logic signed [OUT_WIDTH-1:0] window_c;

  function automatic logic signed [OUT_WIDTH-1:0] sat_out(input logic signed [DW-1:0] v);
    if (v > OUT_MAX) begin
      return OUT_MAX[OUT_WIDTH-1:0];
    end else if (v < OUT_MIN) begin
      return OUT_MIN[OUT_WIDTH-1:0];
    end
    return v[OUT_WIDTH-1:0];
  endfunction

  pdm_clk_gen #(
    .PDM_COUNT_PERIOD(PDM_COUNT_PERIOD)
  ) u_clk_gen (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .en_in      (en_in),
    .mic_clk_out(mic_clk_out),
    .strobe_c   (strobe_c)
  );

  // The closing bit is folded into the result before the tally restarts.
  assign tally_final_c = tally + TW'(mic_data_in);
  assign close_c       = strobe_c && (bit_cnt == CW'(NUM_PDM_SAMPLES - 1));
  assign centred_c     = $signed(DW'(tally_final_c)) - $signed(DW'(NUM_PDM_SAMPLES / 2));
  assign window_c      = sat_out(centred_c);

  // Window accumulator; disable discards the partial window.
  always_ff @(posedge clk_in) begin
    if (rst_in || !en_in) begin
      tally   <= '0;
      bit_cnt <= '0;
    end else if (strobe_c) begin
      bit_cnt <= bit_cnt + CW'(1);
      tally   <= close_c ? '0 : tally_final_c;
    end
  end

`ifdef PDM_DC_REMOVE_EN
  localparam int unsigned AW       = 2 * OUT_WIDTH;
  localparam int unsigned DC_SHIFT = 6;

  logic signed [OUT_WIDTH-1:0] x_q;
  logic                        x_vld;
  logic signed [AW-1:0]        avg;
  logic signed [AW:0]          dc_err_c;
  logic signed [AW:0]          dc_step_c;
  logic signed [DW-1:0]        dc_out_c;

  // avg is fixed point with OUT_WIDTH fraction bits; its integer part is removed from x.
  assign dc_err_c  = $signed({x_q[OUT_WIDTH-1], x_q, {OUT_WIDTH{1'b0}}})
                   - $signed({avg[AW-1], avg});
  assign dc_step_c = dc_err_c >>> DC_SHIFT;
  assign dc_out_c  = $signed({{2{x_q[OUT_WIDTH-1]}}, x_q})
                   - $signed({{2{avg[AW-1]}}, avg[AW-1 -: OUT_WIDTH]});

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      x_q             <= '0;
      x_vld           <= 1'b0;
      avg             <= '0;
      audio_out       <= '0;
      audio_valid_out <= 1'b0;
    end else begin
      x_vld           <= close_c;
      audio_valid_out <= x_vld;
      if (close_c) begin
        x_q <= window_c;
      end
      if (x_vld) begin
        audio_out <= sat_out(dc_out_c);
        avg       <= avg + dc_step_c[AW-1:0];
      end
    end
  end
`else
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      audio_out       <= '0;
      audio_valid_out <= 1'b0;
    end else begin
      audio_valid_out <= close_c;
      if (close_c) begin
        audio_out <= window_c;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pdm_decimator.sv
// Self-checking bench for pdm_decimator: cycle-by-cycle comparison against a
// window-counting reference model, plus literal expectations from the test plan.
module tb_pdm_decimator;

`ifdef PDM_DC_REMOVE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int FIRST_VALID = 8175 + LAT;

  localparam int M_ZERO = 0;
  localparam int M_ONE  = 1;
  localparam int M_ALT  = 2;
  localparam int M_192  = 3;
  localparam int M_RAND = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              mic;
  logic              mic_clk;
  logic signed [7:0] audio;
  logic              valid;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state.
  longint t;
  int     win_n, win_ones;
  int     exp_audio;
  bit     exp_valid, exp_mclk;
  bit     prev_valid;
  bit     x_pend;
  int     x_val;
  int     avg;

  // Per-run observations.
  int first_valid, second_valid, first_rise;
  int val1, val2, mval1, mval2;

  always #5 clk = ~clk;

  pdm_decimator dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .en_in          (en),
    .mic_data_in    (mic),
    .mic_clk_out    (mic_clk),
    .audio_out      (audio),
    .audio_valid_out(valid)
  );

  function automatic int clamp8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, got, want);
    end
  endtask

  // Advance the model by one clock edge with the inputs the DUT sampled.
  task automatic model_edge(input bit r, input bit e, input bit m);
    if (r) begin
      t = 0; win_n = 0; win_ones = 0;
      exp_audio = 0; exp_valid = 0; exp_mclk = 0;
      x_pend = 0; avg = 0;
      return;
    end
    exp_valid = 0;
`ifdef PDM_DC_REMOVE_EN
    if (x_pend) begin
      exp_audio = clamp8(x_val - (avg >>> 8));
      avg       = avg + ((x_val * 256 - avg) >>> 6);
      exp_valid = 1;
      x_pend    = 0;
    end
`endif
    if (e) begin
      if (t % 32 == 15) begin
        win_n++;
        win_ones += int'(m);
        if (win_n == 256) begin
`ifdef PDM_DC_REMOVE_EN
          x_val  = clamp8(win_ones - 128);
          x_pend = 1;
`else
          exp_audio = clamp8(win_ones - 128);
          exp_valid = 1;
`endif
          win_n = 0;
          win_ones = 0;
        end
      end
      t++;
      exp_mclk = (t % 32) >= 16;
    end else begin
      t = 0; win_n = 0; win_ones = 0;
      exp_mclk = 0;
    end
  endtask

  task automatic step(input bit r, input bit e, input bit m);
    rst = r; en = e; mic = m;
    @(posedge clk);
    model_edge(r, e, m);
    #1;
    cyc++;
    chk("audio_out", int'(audio), exp_audio);
    chk("audio_valid_out", int'(valid), int'(exp_valid));
    chk("mic_clk_out", int'(mic_clk), int'(exp_mclk));
    if (prev_valid && valid) begin
      checks++;
      errors++;
      $display("FAIL valid_back_to_back cyc=%0d got 1 expected 0", cyc);
    end
    prev_valid = valid;
  endtask

  function automatic bit gen_mic(input int mode);
    case (mode)
      M_ZERO:  return 1'b0;
      M_ONE:   return 1'b1;
      M_ALT:   return (win_n % 2) == 0;
      M_192:   return (win_n % 4) != 3;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic run(input int n, input int mode);
    first_valid = -1; second_valid = -1; first_rise = -1;
    val1 = 0; val2 = 0; mval1 = 0; mval2 = 0;
    for (int i = 1; i <= n; i++) begin
      step(1'b0, 1'b1, gen_mic(mode));
      if (mic_clk && first_rise < 0) first_rise = i;
      if (valid) begin
        if (first_valid < 0) begin
          first_valid = i; val1 = int'(audio); mval1 = exp_audio;
        end else if (second_valid < 0) begin
          second_valid = i; val2 = int'(audio); mval2 = exp_audio;
        end
      end
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("reset_audio", int'(audio), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_mic_clk", int'(mic_clk), 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mic = 1'b0;
    prev_valid = 1'b0;
    model_edge(1'b1, 1'b0, 1'b0);

    // Constant ones over two windows: timing of clock and first two samples.
    do_reset();
    run(16400, M_ONE);
    chk("first_rise", first_rise, 16);
    chk("ones_first_valid", first_valid, FIRST_VALID);
    chk("ones_second_valid", second_valid, FIRST_VALID + 8192);
    chk("ones_value", val1, 127);
    chk("ones_model", mval1, 127);
    chk("ones_value2", val2, 127);

    // Constant zeros, then a disable gap mid-window, then an all-ones window.
    do_reset();
    run(8180, M_ZERO);
    chk("zeros_first_valid", first_valid, FIRST_VALID);
    chk("zeros_value", val1, -128);
    chk("zeros_model", mval1, -128);
    run(3200, M_ONE);
    chk("pre_gap_no_valid", first_valid, -1);
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      chk("gap_valid", int'(valid), 0);
      chk("gap_audio_held", int'(audio), -128);
    end
    run(8180, M_ONE);
    chk("reenable_first_valid", first_valid, FIRST_VALID);
    chk("reenable_value", val1, 127);

    // Reset mid-window with ones on the data line.
    run(2000, M_ONE);
    step(1'b1, 1'b1, 1'b1);
    chk("midrst_audio", int'(audio), 0);
    chk("midrst_valid", int'(valid), 0);
    run(8180, M_ONE);
    chk("midrst_first_valid", first_valid, FIRST_VALID);
    chk("midrst_value", val1, 127);

    // Alternating bits give mid-scale.
    do_reset();
    run(8180, M_ALT);
    chk("alt_value", val1, 0);
    chk("alt_model", mval1, 0);

    // 192 ones in 256 gives +64; with DC removal the second sample decays to +63.
    do_reset();
`ifdef PDM_DC_REMOVE_EN
    run(16400, M_192);
    chk("p192_first_valid", first_valid, FIRST_VALID);
    chk("p192_value", val1, 64);
    chk("p192_value2", val2, 63);
    chk("p192_model2", mval2, 63);
`else
    run(8180, M_192);
    chk("p192_first_valid", first_valid, FIRST_VALID);
    chk("p192_value", val1, 64);
`endif
    chk("p192_model", mval1, 64);

    // Random density window, checked only against the model.
    do_reset();
    run(8180, M_RAND);
    chk("rand_first_valid", first_valid, FIRST_VALID);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
